vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Generates 640x480 @ 60 Hz VGA raster timing from the pixel clock.
- Sits directly upstream of the VGA colour interface stage.
- Supplies that stage with the current pixel coordinates (row, column) and display_enable.
- Drives the board hsync/vsync pins, delayed to line up with the colour register in the downstream stage.
- Emits frame_start and line_start strobes for game-logic update scheduling.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, sync level while asserted (0 = active-low)
SYNC_DELAY, 1, extra register stages on hsync/vsync, to match downstream colour latency

Ports:
vga_clock  input  1  pixel clock (25.175 MHz nominal)
reset  input  1  asynchronous, active-low reset
row  output  32  current pixel line, 0..V_TOTAL-1 (signed int, same type as downstream)
column  output  32  current pixel column, 0..H_TOTAL-1 (signed int)
display_enable  output  1  high when column < H_VISIBLE and row < V_VISIBLE
hsync  output  1  horizontal sync, delayed SYNC_DELAY clocks relative to row/column
vsync  output  1  vertical sync, delayed SYNC_DELAY clocks relative to row/column
line_start  output  1  one-clock pulse when column == 0
frame_start  output  1  one-clock pulse when row == 0 and column == 0

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Internal next-pixel counters h_next/v_next:
  - Reset to 0.
  - h_next increments each clock and wraps H_TOTAL-1 -> 0.
  - v_next increments only on the h_next wrap and wraps V_TOTAL-1 -> 0.
- All outputs are registered and reflect the pixel (h_next, v_next) captured at the same edge.
- First rising edge after reset release: column=0, row=0, display_enable=1, line_start=1, frame_start=1.
- Sync regions, evaluated on the registered pixel:
  - hsync asserted iff H_VISIBLE+H_FRONT <= column < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vsync asserted iff V_VISIBLE+V_FRONT <= row < V_VISIBLE+V_FRONT+V_SYNC (490..491), for entire lines.
- Sync delay: raw sync levels pass through a SYNC_DELAY-deep shift register.
  - hsync/vsync lag row/column by exactly SYNC_DELAY clocks.
  - SYNC_DELAY=0 means no extra stage.
- Reset asserted, asynchronous and at any point mid-frame:
  - row=0, column=0, display_enable=0, line_start=0, frame_start=0.
  - hsync=vsync=!SYNC_ACTIVE, including all delay stages.
  - Counters return to 0; the frame restarts cleanly on release.
- Boundaries:
  - column 799 -> 0 with row r -> r+1.
  - row 524, column 799 -> row 0, column 0, with frame_start.
  - No column or row value outside its range is ever output.
- display_enable deasserts at column 640 and at row 480, and is low through all blanking.
- Arithmetic is 32-bit unsigned-compatible; values are always non-negative.

Test Plan:
- Reset held 10 clocks -> row=0, column=0, display_enable=0, strobes 0, hsync=vsync=1. Release -> first edge gives (0,0), display_enable=1, frame_start=1, line_start=1.
- Run one line -> column counts 0..799. display_enable high for 640 clocks then low for 160. Next clock: column=0, row=1, line_start=1, frame_start=0.
- hsync with SYNC_DELAY=1 -> hsync low for exactly 96 clocks. It first goes low one clock after column==656 is output. No glitch elsewhere.
- Full frame -> 525 line_start pulses and one frame_start pulse per 420000 clocks. display_enable high for 307200 clocks. vsync low for exactly 1600 clocks, starting one clock after row 490 column 0.
- Frame wrap -> after row=524, column=799, the next edge gives row=0, column=0, frame_start=1.
- Reset asserted mid-line (row 200, column 300), asynchronously between edges -> outputs go to reset values immediately. After release, the sequence restarts at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: pixel coordinates, display enable, line/frame strobes, hsync/vsync.
// Latency: row/column/strobes are registered one clock after the next-pixel counters; syncs lag a further SYNC_DELAY clocks.
// Backpressure: none; the raster free-runs on the pixel clock and never stalls.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter int unsigned SYNC_DELAY  = 1
) (
  input  logic               vga_clock,
  input  logic               reset,
  output logic signed [31:0] row,
  output logic signed [31:0] column,
  output logic               display_enable,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [31:0] H_TOTAL  = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [31:0] V_TOTAL  = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  // Next-pixel counters: the pixel that will be presented at the coming edge.
  logic [31:0] h_next_q, h_next_d;
  logic [31:0] v_next_q, v_next_d;

  // Registered pixel outputs.
  logic [31:0] column_q, row_q;
  logic        de_q, ls_q, fs_q;

  // Raw sync levels decoded from the registered pixel.
  logic        hs_raw, vs_raw;

  // Advance the horizontal counter every clock; the vertical one only on horizontal wrap.
  always_comb begin
    h_next_d = h_next_q + 32'd1;
    v_next_d = v_next_q;
    if (h_next_q == H_TOTAL - 32'd1) begin
      h_next_d = 32'd0;
      if (v_next_q == V_TOTAL - 32'd1) begin
        v_next_d = 32'd0;
      end else begin
        v_next_d = v_next_q + 32'd1;
      end
    end
  end

  // Next-pixel counter state.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      h_next_q <= 32'd0;
      v_next_q <= 32'd0;
    end else begin
      h_next_q <= h_next_d;
      v_next_q <= v_next_d;
    end
  end

  // Present the captured pixel and its enable/strobes together at the same edge.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      column_q <= 32'd0;
      row_q    <= 32'd0;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      column_q <= h_next_q;
      row_q    <= v_next_q;
      de_q     <= (h_next_q < H_VISIBLE) && (v_next_q < V_VISIBLE);
      ls_q     <= (h_next_q == 32'd0);
      fs_q     <= (h_next_q == 32'd0) && (v_next_q == 32'd0);
    end
  end

  // Sync windows are decoded from the registered pixel so the delay line counts from row/column.
  always_comb begin
    hs_raw = ((column_q >= HS_START) && (column_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw = ((row_q >= VS_START) && (row_q < VS_END))       ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_sync_delay
      assign hsync = hs_raw;
      assign vsync = vs_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q;
      logic [SYNC_DELAY-1:0] vs_pipe_q;

      // Delay line aligning syncs with the downstream colour register; resets to idle level.
      always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
          hs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
          vs_pipe_q <= {SYNC_DELAY{~SYNC_ACTIVE}};
        end else begin
          hs_pipe_q[0] <= hs_raw;
          vs_pipe_q[0] <= vs_raw;
          for (int i = 1; i < int'(SYNC_DELAY); i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
          end
        end
      end

      assign hsync = hs_pipe_q[SYNC_DELAY-1];
      assign vsync = vs_pipe_q[SYNC_DELAY-1];
    end
  endgenerate

  assign column         = $signed(column_q);
  assign row            = $signed(row_q);
  assign display_enable = de_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: one full 640x480 instance and one shrunken-raster instance on a shared clock/reset.
// Latency: model predicts outputs from the number of edges since reset release (pixel = edges-1, syncs lag by SYNC_DELAY).
// Backpressure: none; stimulus is only clock and asynchronous reset.
module tb_vga_timing_generator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic signed [31:0] f_row, f_col, s_row, s_col;
  logic f_de, f_hs, f_vs, f_ls, f_fs;
  logic s_de, s_hs, s_vs, s_ls, s_fs;

  vga_timing_generator u_full (
    .vga_clock(clk), .reset(rst_n), .row(f_row), .column(f_col),
    .display_enable(f_de), .hsync(f_hs), .vsync(f_vs),
    .line_start(f_ls), .frame_start(f_fs)
  );

  // Shrunken raster: 15 clocks/line (8 visible, hsync cols 10..12), 13 lines (6 visible, vsync rows 8..9), 2-deep sync delay.
  vga_timing_generator #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b0), .SYNC_DELAY(2)
  ) u_small (
    .vga_clock(clk), .reset(rst_n), .row(s_row), .column(s_col),
    .display_enable(s_de), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs)
  );

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic de, hs, vs, ls, fs;
  } vout_t;

  int checks = 0;
  int errors = 0;
  int edges;
  bit first_run = 1'b1;

  // Tallies over the first line (full) and first frame (small).
  int fde_cnt = 0, fhs_cnt = 0, fhs_first = 0, fhs_first_col = 0;
  int sls_cnt = 0, sfs_cnt = 0, sde_cnt = 0, svs_cnt = 0, shs_cnt = 0;

  // Edges since reset release; the pixel shown after edge n is raster index n-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic vout_t model(input int n, input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb, input int d);
    int ht, vt, p, q, c, r;
    vout_t o;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (n > 0) begin
      p = (n - 1) % (ht * vt);
      c = p % ht;
      r = p / ht;
      o.col = 32'(c);
      o.row = 32'(r);
      o.de = (c < hv) && (r < vv);
      o.ls = (c == 0);
      o.fs = (p == 0);
    end
    if (n - d > 0) begin
      q = (n - 1 - d) % (ht * vt);
      c = q % ht;
      r = q / ht;
      o.hs = !((c >= hv + hf) && (c < hv + hf + hsw));
      o.vs = !((r >= vv + vf) && (r < vv + vf + vsw));
    end
    return o;
  endfunction

  // Per-cycle comparison of both instances against the model, plus window tallies.
  always @(negedge clk) begin
    vout_t ef, af, es, as_;
    ef = model(edges, 640, 16, 96, 48, 480, 10, 2, 33, 1);
    es = model(edges, 8, 2, 3, 2, 6, 2, 2, 3, 2);
    af.row = f_row; af.col = f_col; af.de = f_de; af.hs = f_hs; af.vs = f_vs; af.ls = f_ls; af.fs = f_fs;
    as_.row = s_row; as_.col = s_col; as_.de = s_de; as_.hs = s_hs; as_.vs = s_vs; as_.ls = s_ls; as_.fs = s_fs;
    checks++;
    if (af !== ef) begin
      errors++;
      $display("FAIL full_cycle edge=%0d got row=%0d col=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want row=%0d col=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               edges, af.row, af.col, af.de, af.hs, af.vs, af.ls, af.fs, ef.row, ef.col, ef.de, ef.hs, ef.vs, ef.ls, ef.fs);
    end
    checks++;
    if (as_ !== es) begin
      errors++;
      $display("FAIL small_cycle edge=%0d got row=%0d col=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want row=%0d col=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               edges, as_.row, as_.col, as_.de, as_.hs, as_.vs, as_.ls, as_.fs, es.row, es.col, es.de, es.hs, es.vs, es.ls, es.fs);
    end
    if (first_run && edges >= 1 && edges <= 800) begin
      if (f_de) fde_cnt++;
      if (!f_hs) begin
        if (fhs_cnt == 0) begin
          fhs_first = edges;
          fhs_first_col = f_col;
        end
        fhs_cnt++;
      end
    end
    if (first_run && edges >= 1 && edges <= 195) begin
      if (s_ls) sls_cnt++;
      if (s_fs) sfs_cnt++;
      if (s_de) sde_cnt++;
      if (!s_vs) svs_cnt++;
      if (!s_hs) shs_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance to just after the negedge at which the edge counter reads n.
  task automatic wait_edge(input int n);
    int budget;
    budget = 5000;
    @(negedge clk);
    while (edges != n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #1;
    if (edges != n) begin
      checks++;
      errors++;
      $display("FAIL wait_edge got %0d want %0d", edges, n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_row", f_row, 0);
    chk("rst_col", f_col, 0);
    chk("rst_de", f_de, 0);
    chk("rst_ls", f_ls, 0);
    chk("rst_fs", f_fs, 0);
    chk("rst_hs", f_hs, 1);
    chk("rst_vs", f_vs, 1);

    rst_n = 1'b1;
    wait_edge(1);
    chk("first_row", f_row, 0);
    chk("first_col", f_col, 0);
    chk("first_de", f_de, 1);
    chk("first_ls", f_ls, 1);
    chk("first_fs", f_fs, 1);
    chk("small_first_fs", s_fs, 1);

    // Small raster frame wrap: last pixel then back to origin.
    wait_edge(195);
    chk("small_last_row", s_row, 12);
    chk("small_last_col", s_col, 14);
    wait_edge(196);
    chk("small_wrap_row", s_row, 0);
    chk("small_wrap_col", s_col, 0);
    chk("small_wrap_fs", s_fs, 1);
    chk("small_ls_per_frame", sls_cnt, 13);
    chk("small_fs_per_frame", sfs_cnt, 1);
    chk("small_de_per_frame", sde_cnt, 48);
    chk("small_vs_low", svs_cnt, 30);
    chk("small_hs_low", shs_cnt, 39);

    // Full raster: end of line 0 and wrap into line 1.
    wait_edge(800);
    chk("eol_col", f_col, 799);
    chk("eol_row", f_row, 0);
    chk("eol_de", f_de, 0);
    wait_edge(801);
    chk("line1_col", f_col, 0);
    chk("line1_row", f_row, 1);
    chk("line1_ls", f_ls, 1);
    chk("line1_fs", f_fs, 0);
    chk("line_de_count", fde_cnt, 640);
    chk("line_hs_low", fhs_cnt, 96);
    chk("hs_first_edge", fhs_first, 658);
    chk("hs_first_col", fhs_first_col, 657);

    // Mid-line asynchronous reset between edges.
    wait_edge(1101);
    chk("mid_row", f_row, 1);
    chk("mid_col", f_col, 300);
    chk("mid_small_vs", s_vs, 0);
    first_run = 1'b0;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_row", f_row, 0);
    chk("async_col", f_col, 0);
    chk("async_de", f_de, 0);
    chk("async_ls", f_ls, 0);
    chk("async_fs", f_fs, 0);
    chk("async_hs", f_hs, 1);
    chk("async_vs", f_vs, 1);
    chk("async_small_vs", s_vs, 1);
    chk("async_small_row", s_row, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_edge(1);
    chk("restart_row", f_row, 0);
    chk("restart_col", f_col, 0);
    chk("restart_fs", f_fs, 1);
    chk("restart_small_fs", s_fs, 1);
    wait_edge(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
